// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and requester IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the port not served last.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = PORT_DATA;
    end else begin
      grant = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port 0) and data access (port 1),
// one transaction at a time, stalling the waiting side through its BUSYWAIT.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          P0_READ,
  input  logic          P0_WRITE,
  input  logic [AW-1:0] P0_ADDRESS,
  input  logic [DW-1:0] P0_WRITEDATA,
  output logic [DW-1:0] P0_READDATA,
  output logic          P0_BUSYWAIT,
  input  logic          P1_READ,
  input  logic          P1_WRITE,
  input  logic [AW-1:0] P1_ADDRESS,
  input  logic [DW-1:0] P1_WRITEDATA,
  output logic [DW-1:0] P1_READDATA,
  output logic          P1_BUSYWAIT,
  output logic          MEM_READ,
  output logic          MEM_WRITE,
  output logic [AW-1:0] MEM_ADDRESS,
  output logic [DW-1:0] MEM_WRITEDATA,
  input  logic [DW-1:0] MEM_READDATA,
  input  logic          MEM_BUSYWAIT
);

  arb_state_t    state;
  logic          owner;
  logic          last;
  logic          op_write;
  logic          p0_req;
  logic          p1_req;
  logic          grant;
  logic          grant_vld;
  logic          gnt_write;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

  assign p0_req = P0_READ | P0_WRITE;
  assign p1_req = P1_READ | P1_WRITE;

  // Only the owner is released, and only for the single DONE cycle.
  assign P0_BUSYWAIT = p0_req & ~((state == ST_DONE) && (owner == PORT_IF));
  assign P1_BUSYWAIT = p1_req & ~((state == ST_DONE) && (owner == PORT_DATA));

  rr_pick2 u_pick (
    .req0  (p0_req),
    .req1  (p1_req),
    .last  (last),
    .grant (grant),
    .valid (grant_vld)
  );

  // A request with both READ and WRITE high is a write.
  always_comb begin
    gnt_write = P0_WRITE;
    gnt_addr  = P0_ADDRESS;
    gnt_wdata = P0_WRITEDATA;
    if (grant == PORT_DATA) begin
      gnt_write = P1_WRITE;
      gnt_addr  = P1_ADDRESS;
      gnt_wdata = P1_WRITEDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      owner         <= PORT_IF;
      last          <= PORT_DATA;
      op_write      <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      P0_READDATA   <= '0;
      P1_READDATA   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            owner         <= grant;
            op_write      <= gnt_write;
            MEM_ADDRESS   <= gnt_addr;
            MEM_WRITEDATA <= gnt_wdata;
            MEM_WRITE     <= gnt_write;
            MEM_READ      <= ~gnt_write;
            state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The op always runs to completion, even if the owner withdraws.
          if (!MEM_BUSYWAIT) begin
            if (!op_write) begin
              if (owner == PORT_DATA) begin
                P1_READDATA <= MEM_READDATA;
              end else begin
                P0_READDATA <= MEM_READDATA;
              end
            end
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          last  <= owner;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences, and a
// randomized two-requester run against a transaction-level memory model.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          P0_READ = 1'b0, P0_WRITE = 1'b0;
  logic [AW-1:0] P0_ADDRESS = '0;
  logic [DW-1:0] P0_WRITEDATA = '0;
  logic [DW-1:0] P0_READDATA;
  logic          P0_BUSYWAIT;
  logic          P1_READ = 1'b0, P1_WRITE = 1'b0;
  logic [AW-1:0] P1_ADDRESS = '0;
  logic [DW-1:0] P1_WRITEDATA = '0;
  logic [DW-1:0] P1_READDATA;
  logic          P1_BUSYWAIT;
  logic          MEM_READ, MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .P0_READ(P0_READ), .P0_WRITE(P0_WRITE), .P0_ADDRESS(P0_ADDRESS),
    .P0_WRITEDATA(P0_WRITEDATA), .P0_READDATA(P0_READDATA), .P0_BUSYWAIT(P0_BUSYWAIT),
    .P1_READ(P1_READ), .P1_WRITE(P1_WRITE), .P1_ADDRESS(P1_ADDRESS),
    .P1_WRITEDATA(P1_WRITEDATA), .P1_READDATA(P1_READDATA), .P1_BUSYWAIT(P1_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory model: busy for 3 cycles of a strobe, completes on the 4th.
  logic [7:0] mem [256];
  int         mcnt;
  logic       init_mem = 1'b0;

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hAB : (8'(i) ^ 8'h5A);
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt < 3);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mcnt <= 0;
    end else if (MEM_READ | MEM_WRITE) begin
      if (mcnt >= 3) begin
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        mcnt <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  typedef struct {
    int         port;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       exp_mr;
    logic       exp_mw;
    logic [7:0] exp_rd0;
    logic [7:0] exp_rd1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      P0_READ = rd; P0_WRITE = wr; P0_ADDRESS = a; P0_WRITEDATA = d;
    end else begin
      P1_READ = rd; P1_WRITE = wr; P1_ADDRESS = a; P1_WRITEDATA = d;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic busy(input int p);
    return (p == 0) ? P0_BUSYWAIT : P1_BUSYWAIT;
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    init_mem = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    RESET = 1'b0;
    init_mem = 1'b0;
  endtask

  task automatic wait_done(input string name, input int p, input int maxc,
                           output int bc, output bit ok);
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge CLK);
      if (!busy(p)) ok = 1'b1;
      else bc++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout port=%0d after %0d cycles", name, p, maxc);
    end
  endtask

  task automatic wait_mem_read(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      seen = MEM_READ;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    bit   seen;
    bit   done;
    int   bc;
    v = vecs[idx];
    seen = 1'b0;
    done = 1'b0;
    bc = 0;
    tick();
    drive(v.port, v.rd, v.wr, v.addr, v.wd);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if ((MEM_READ | MEM_WRITE) && !seen) begin
        seen = 1'b1;
        chk($sformatf("v%0d_mem_read", idx), 32'(MEM_READ), 32'(v.exp_mr));
        chk($sformatf("v%0d_mem_write", idx), 32'(MEM_WRITE), 32'(v.exp_mw));
        chk($sformatf("v%0d_mem_addr", idx), 32'(MEM_ADDRESS), 32'(v.addr));
        if (v.exp_mw) chk($sformatf("v%0d_mem_wdata", idx), 32'(MEM_WRITEDATA), 32'(v.wd));
      end
      if (!busy(v.port)) done = 1'b1;
      else bc++;
    end
    chk($sformatf("v%0d_strobe_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(bc), 32'd5);
    chk($sformatf("v%0d_rd0", idx), 32'(P0_READDATA), 32'(v.exp_rd0));
    chk($sformatf("v%0d_rd1", idx), 32'(P1_READDATA), 32'(v.exp_rd1));
    tick();
    drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk($sformatf("v%0d_strobes_idle", idx), 32'(MEM_READ | MEM_WRITE), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] ref_mem [256];
  logic [7:0] ref_rd [2];
  bit         act [2];
  logic       wrq [2];
  logic       rdq [2];
  logic [7:0] aq [2];
  logic [7:0] dq [2];
  int         wc [2];

  initial begin
    int   bc;
    bit   ok;
    bit   got;
    int   served;
    int   sel;
    logic bw;
    logic [7:0] rdv;

    vecs[0] = '{0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'hAB, 8'h58};
    vecs[1] = '{1, 1'b0, 1'b1, 8'h05, 8'h3C, 1'b0, 1'b1, 8'hAB, 8'h58};
    vecs[2] = '{1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'hAB, 8'h3C};
    vecs[3] = '{0, 1'b1, 1'b1, 8'h20, 8'h77, 1'b0, 1'b1, 8'hAB, 8'h3C};
    vecs[4] = '{0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h77, 8'h3C};
    vecs[5] = '{1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'h77, 8'h59};

    // Reset values
    do_reset();
    @(negedge CLK);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_mem_wdata", 32'(MEM_WRITEDATA), 32'd0);
    chk("rst_rd0", 32'(P0_READDATA), 32'd0);
    chk("rst_rd1", 32'(P1_READDATA), 32'd0);
    chk("rst_bw0", 32'(P0_BUSYWAIT), 32'd0);
    chk("rst_bw1", 32'(P1_BUSYWAIT), 32'd0);

    // Read with request held past DONE: BUSYWAIT is low for one cycle only
    tick();
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_done("t1_first", 0, 20, bc, ok);
    chk("t1_latency", 32'(bc), 32'd5);
    chk("t1_rd0", 32'(P0_READDATA), 32'hAB);
    tick();
    @(negedge CLK);
    chk("t1_bw_one_cycle", 32'(P0_BUSYWAIT), 32'd1);
    wait_done("t1_second", 0, 20, bc, ok);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Tie after reset: port 0 first, port 1 held off until its own DONE
    do_reset();
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    wait_done("t2_p0", 0, 20, bc, ok);
    chk("t2_p0_latency", 32'(bc), 32'd5);
    chk("t2_p1_still_wait", 32'(P1_BUSYWAIT), 32'd1);
    chk("t2_rd0", 32'(P0_READDATA), 32'h5B);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_done("t2_p1", 1, 20, bc, ok);
    chk("t2_p1_latency", 32'(bc), 32'd5);
    chk("t2_rd1", 32'(P1_READDATA), 32'h58);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Continuous requests from both ports alternate
    do_reset();
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge CLK);
        if (!P0_BUSYWAIT || !P1_BUSYWAIT) got = 1'b1;
      end
      chk("t3_got", 32'(got), 32'd1);
      served = P0_BUSYWAIT ? 1 : 0;
      chk($sformatf("t3_order%0d", k), 32'(served), 32'(k % 2));
      tick();
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset in the second ACCESS cycle
    tick();
    drive(1, 1'b1, 1'b0, 8'h30, 8'h00);
    wait_mem_read("t5_access");
    tick();
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("t5_mem_read", 32'(MEM_READ), 32'd0);
    chk("t5_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("t5_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    chk("t5_rd0", 32'(P0_READDATA), 32'd0);
    chk("t5_rd1", 32'(P1_READDATA), 32'd0);
    tick();
    RESET = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (!P0_BUSYWAIT || !P1_BUSYWAIT) got = 1'b1;
    end
    chk("t5_tie_got", 32'(got), 32'd1);
    chk("t5_tie_p0_first", 32'(P0_BUSYWAIT), 32'd0);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_done("t5_p1", 1, 20, bc, ok);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Port 0 withdraws during ACCESS; its read still completes before port 1
    tick();
    drive(0, 1'b1, 1'b0, 8'h07, 8'h00);
    wait_mem_read("t6_access");
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h06, 8'h00);
    wait_done("t6_p1", 1, 30, bc, ok);
    chk("t6_p1_latency", 32'(bc), 32'd9);
    chk("t6_rd0", 32'(P0_READDATA), 32'h5D);
    chk("t6_rd1", 32'(P1_READDATA), 32'h5C);
    chk("t6_bw0", 32'(P0_BUSYWAIT), 32'd0);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Randomized traffic from both requesters
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      ref_rd[p] = 8'h00;
      act[p] = 1'b0;
      wc[p] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      for (int p = 0; p < 2; p++) begin
        bw = busy(p);
        rdv = (p == 0) ? P0_READDATA : P1_READDATA;
        if (act[p]) begin
          if (!bw) begin
            if (wrq[p]) ref_mem[aq[p]] = dq[p];
            else ref_rd[p] = ref_mem[aq[p]];
            checks++;
            if (wc[p] > 11) begin
              errors++;
              $display("FAIL rnd_wait port=%0d waited=%0d limit=11", p, wc[p]);
            end
            act[p] = 1'b0;
          end else begin
            wc[p]++;
          end
        end else begin
          chk($sformatf("rnd_idle_bw%0d", p), 32'(bw), 32'd0);
        end
        chk($sformatf("rnd_rdata%0d", p), 32'(rdv), 32'(ref_rd[p]));
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && ($urandom_range(0, 2) == 0)) begin
          act[p] = 1'b1;
          wc[p] = 0;
          sel = int'($urandom_range(0, 3));
          rdq[p] = (sel != 2);
          wrq[p] = (sel >= 2);
          aq[p] = 8'($urandom_range(0, 7));
          dq[p] = 8'($urandom);
        end
        if (act[p]) drive(p, rdq[p], wrq[p], aq[p], dq[p]);
        else drive(p, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (act[p]) chk($sformatf("rnd_final_wait%0d", p), 32'(wc[p] <= 11), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
